// File: rtl/bram_read_arbiter_pkg.sv
// Shared FSM encodings and constants for the BRAM read-port arbiter.
package bram_read_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_BURST_WIDTH = 4;

endpackage

// File: rtl/bram_read_arbiter_rr_pick.sv
// Combinational circular priority picker: first pending index at or after start,
// optionally skipping one excluded index.
module bram_read_arbiter_rr_pick
    import bram_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned LOG_NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]     pending,
    input  logic [LOG_NUM_REQ-1:0] start,
    input  logic                   exclude_en,
    input  logic [LOG_NUM_REQ-1:0] exclude,
    output logic                   found,
    output logic [NUM_REQ-1:0]     onehot,
    output logic [LOG_NUM_REQ-1:0] index
);

    logic [LOG_NUM_REQ-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        // NUM_REQ is a power of two, so the index addition wraps for free.
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = start + LOG_NUM_REQ'(i);
            if (!found && pending[cand] && !(exclude_en && cand == exclude)) begin
                found = 1'b1;
                index = cand;
            end
        end
        onehot = found ? (NUM_REQ'(1) << index) : '0;
    end

endmodule

// File: rtl/bram_read_arbiter.sv
// Burst-limited arbiter sharing one BRAM read port among NUM_REQ requesters.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed (lowest index) priority instead of round-robin.
module bram_read_arbiter
    import bram_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned LOG_NUM_REQ     = 2,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned LOG_MAX_ADDRESS = 16,
    parameter int unsigned BRAM_LATENCY    = 1,
    parameter int unsigned MAX_BURST       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 request_in,
    input  logic [NUM_REQ*LOG_MAX_ADDRESS-1:0] address_in,
    output logic [NUM_REQ-1:0]                 grant_out,
    output logic [LOG_MAX_ADDRESS-1:0]         bram_address,
    output logic                               bram_enable,
    input  logic [DATA_WIDTH-1:0]              bram_data,
    output logic [NUM_REQ-1:0]                 valid_out,
    output logic [DATA_WIDTH-1:0]              data_out
);

    localparam logic [MAX_BURST_WIDTH-1:0] MaxBurstCnt = MAX_BURST_WIDTH'(MAX_BURST);
    localparam logic [MAX_BURST_WIDTH-1:0] CntOne      = MAX_BURST_WIDTH'(1);

    arb_state_e                 state_q, state_d;
    logic [LOG_NUM_REQ-1:0]     owner_q, owner_d;
    logic [MAX_BURST_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic                       rst_q;
    logic                       grant_any;
    logic [LOG_NUM_REQ-1:0]     grant_idx;
    logic [NUM_REQ-1:0]         owner_onehot;

    logic                       pick_found;
    logic [NUM_REQ-1:0]         pick_onehot;
    logic [LOG_NUM_REQ-1:0]     pick_index;
    logic [LOG_NUM_REQ-1:0]     pick_start;

    logic [BRAM_LATENCY-1:0]    pipe_vld_q;
    logic [LOG_NUM_REQ-1:0]     pipe_idx_q [BRAM_LATENCY];

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign pick_start = '0;
`else
    logic [LOG_NUM_REQ-1:0] last_grant_q;

    assign pick_start = last_grant_q + LOG_NUM_REQ'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= LOG_NUM_REQ'(NUM_REQ - 1);
        end else if (grant_any) begin
            last_grant_q <= grant_idx;
        end
    end
`endif

    bram_read_arbiter_rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .LOG_NUM_REQ(LOG_NUM_REQ)
    ) u_rr_pick (
        .pending   (request_in),
        .start     (pick_start),
        .exclude_en(state_q == StBurst),
        .exclude   (owner_q),
        .found     (pick_found),
        .onehot    (pick_onehot),
        .index     (pick_index)
    );

    assign owner_onehot = NUM_REQ'(1) << owner_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        grant_any   = 1'b0;
        grant_idx   = owner_q;
        grant_out   = '0;
        // No grants in the reset cycle nor in the one that follows it.
        if (!rst && !rst_q) begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_any   = 1'b1;
                        grant_idx   = pick_index;
                        grant_out   = pick_onehot;
                        owner_d     = pick_index;
                        burst_cnt_d = CntOne;
                        state_d     = StBurst;
                    end
                end
                StBurst: begin
                    if (request_in[owner_q] && burst_cnt_q < MaxBurstCnt) begin
                        grant_any   = 1'b1;
                        grant_out   = owner_onehot;
                        burst_cnt_d = burst_cnt_q + CntOne;
                    end else if (pick_found) begin
                        grant_any   = 1'b1;
                        grant_idx   = pick_index;
                        grant_out   = pick_onehot;
                        owner_d     = pick_index;
                        burst_cnt_d = CntOne;
                    end else if (request_in[owner_q]) begin
                        grant_any   = 1'b1;
                        grant_out   = owner_onehot;
                        burst_cnt_d = CntOne;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bram_enable  = grant_any;
    assign bram_address = grant_any ?
        address_in[int'(grant_idx)*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            rst_q       <= 1'b1;
            pipe_vld_q  <= '0;
            for (int i = 0; i < int'(BRAM_LATENCY); i++) pipe_idx_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            burst_cnt_q   <= burst_cnt_d;
            rst_q         <= 1'b0;
            pipe_vld_q[0] <= grant_any;
            pipe_idx_q[0] <= grant_idx;
            for (int i = 1; i < int'(BRAM_LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    assign valid_out = (pipe_vld_q[BRAM_LATENCY-1] && !rst) ?
        (NUM_REQ'(1) << pipe_idx_q[BRAM_LATENCY-1]) : '0;
    assign data_out  = bram_data;

endmodule

// File: doc/bram_read_arbiter.md
BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one block-RAM read port.
REQ-002 Parameter LOG_NUM_REQ, 2, index width; NUM_REQ = 2**LOG_NUM_REQ.
REQ-003 Parameter DATA_WIDTH, 8, BRAM data width.
REQ-004 Parameter LOG_MAX_ADDRESS, 16, BRAM address width.
REQ-005 Parameter BRAM_LATENCY, 1, cycles from BRAM enable to BRAM data valid; legal range 1..4.
REQ-006 Parameter MAX_BURST, 4, maximum consecutive grants to one requester; legal range 1..15.
REQ-007 The design SHALL have one clock. Reset is synchronous and active-high.
REQ-008 clk  in  1  clock; all logic on rising edge.
REQ-009 rst  in  1  synchronous reset, active-high.
REQ-010 request_in  in  NUM_REQ  per-requester read request.
REQ-011 address_in  in  NUM_REQ*LOG_MAX_ADDRESS  per-requester address; slice i is requester i.
REQ-012 grant_out  out  NUM_REQ  one-hot; request accepted this cycle.
REQ-013 bram_address  out  LOG_MAX_ADDRESS  address to BRAM.
REQ-014 bram_enable  out  1  BRAM read strobe.
REQ-015 bram_data  in  DATA_WIDTH  BRAM read data, valid BRAM_LATENCY cycles after enable.
REQ-016 valid_out  out  NUM_REQ  one-hot; data_out belongs to requester i.
REQ-017 data_out  out  DATA_WIDTH  returned data, broadcast to all requesters.

Function
REQ-018 Arbitration SHALL be combinational from registered state: grant_out, bram_enable and bram_address SHALL be valid in the same cycle as request_in.
REQ-019 At most one grant per cycle; bram_enable = |grant_out; bram_address = address_in slice of the granted index, else 0.
REQ-020 A requester SHALL hold request_in and its address until it sees grant_out[i]; each grant consumes exactly one read.
REQ-021 FSM states IDLE and BURST; reset state IDLE.
REQ-022 IDLE: no requests -> stay IDLE, no grant; any request -> grant the winner per REQ-025, load owner, burst_cnt = 1, go to BURST.
REQ-023 BRAM_READ_ARBITER SHALL, in BURST, grant the owner again while request_in[owner]=1 and burst_cnt < MAX_BURST, incrementing burst_cnt.
REQ-024 BURST exit: owner drops its request or burst_cnt = MAX_BURST -> arbitrate the same cycle among the others (owner last). If any other requester is pending, grant it and restart BURST with burst_cnt = 1; otherwise the next state depends on the owner. Owner still requesting -> re-grant it with burst_cnt = 1. Nobody requesting -> IDLE.
REQ-025 Default policy is round-robin: search starts at last_grant+1 mod NUM_REQ; last_grant updates on every grant; wrap from NUM_REQ-1 to 0.
REQ-026 Return path is a BRAM_LATENCY-deep shift register of {valid, index}; valid_out[index] = stage-out valid; data_out = bram_data (not re-registered).
REQ-027 The return path SHALL never stall; requesters SHALL accept data whenever valid_out[i]=1. Back-to-back grants yield back-to-back valid_out.
REQ-028 burst_cnt is 4 bits and SHALL saturate at MAX_BURST; no wrap.

Reset
REQ-029 On rst the state SHALL be IDLE. burst_cnt and last_grant SHALL be set: burst_cnt = 0, last_grant = NUM_REQ-1, so requester 0 wins first. All pipeline valid bits SHALL be cleared.
REQ-030 Outputs during reset cycle and the cycle after: grant_out=0, bram_enable=0, bram_address=0, valid_out=0, data_out=bram_data.
REQ-031 Reset mid-operation SHALL drop in-flight reads silently; no valid_out for them after reset.

Configuration
REQ-032 Macro BRAM_ARB_FIXED_PRIO_EN defined: the REQ-025 winner SHALL be the lowest pending index. The last_grant register SHALL be omitted. Burst rules of REQ-023/024 are unchanged, and owner-last exclusion still applies.
REQ-033 BRAM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-025.

Structure
REQ-034 Shared package: FSM state encodings (IDLE=0, BURST=1) and constant MAX_BURST_WIDTH=4.
REQ-035 One sub-module, rr_pick: combinational priority picker, inputs pending mask, start index and exclude index; outputs one-hot and index.

Verification
REQ-036 Reset, then request_in=0001 with addr0=0x0010 held -> grant_out=0001 each cycle, addresses as driven, valid_out[0] BRAM_LATENCY cycles after each grant.
REQ-037 request_in=1111 held, MAX_BURST=4 -> grants to 0,0,0,0,1,1,1,1,2,... Under FIXED_PRIO_EN: 0x4, 1x4, 0x4, 1x4.
REQ-038 Req 2 burst with req 0 arriving, req 2 drops after 2 grants -> third cycle grant_out=0001, no idle cycle.
REQ-039 BRAM_LATENCY=3, alternating grants 1,3,1 -> valid_out 0010,1000,0010 exactly 3 cycles after each, data_out=bram_data.
REQ-040 rst pulsed one cycle with 2 reads in flight -> no valid_out afterwards; next grant goes to requester 0.
REQ-041 Single requester, MAX_BURST=1 -> continuous re-grant each cycle, burst_cnt stays 1, no gaps.
